// File: rtl/hv_wdg_rsp_ctrl_if.sv
// Signal bundle between the HV watchdog response controller and its OWT rx/tx neighbours.
// The slave modport is the controller side; the master modport drives the frames and the ack.
interface hv_wdg_rsp_ctrl_if;
  logic       i_wdg_en;
  logic       i_owt_rx_frm_vld;
  logic       i_owt_rx_frm_is_wdg;
  logic       i_owt_rx_frm_crc_err;
  logic [1:0] i_wdgtmo_config;
  logic       o_wdg_owt_tx_rsp_req;
  logic       i_owt_tx_wdg_rsp_ack;
  logic [1:0] o_wdg_rsp_status;
  logic       o_wdg_lv_lost;
  logic       o_wdg_crc_err_alarm;
  logic       o_wdg_rsp_ovr;
  logic       o_wdg_tx_stall;

  modport slave (
    input  i_wdg_en, i_owt_rx_frm_vld, i_owt_rx_frm_is_wdg, i_owt_rx_frm_crc_err,
           i_wdgtmo_config, i_owt_tx_wdg_rsp_ack,
    output o_wdg_owt_tx_rsp_req, o_wdg_rsp_status, o_wdg_lv_lost,
           o_wdg_crc_err_alarm, o_wdg_rsp_ovr, o_wdg_tx_stall
  );

  modport master (
    output i_wdg_en, i_owt_rx_frm_vld, i_owt_rx_frm_is_wdg, i_owt_rx_frm_crc_err,
           i_wdgtmo_config, i_owt_tx_wdg_rsp_ack,
    input  o_wdg_owt_tx_rsp_req, o_wdg_rsp_status, o_wdg_lv_lost,
           o_wdg_crc_err_alarm, o_wdg_rsp_ovr, o_wdg_tx_stall
  );
endinterface

// File: rtl/hv_wdg_rsp_ctrl.sv
// HV-side watchdog responder: answers LV refresh frames over OWT, tracks LV loss and CRC errors.
// Optional tx-ack timeout enabled by defining HV_WDG_RSP_ACK_TMO_EN.
module hv_wdg_rsp_ctrl #(
    parameter int WDG_CNT_W   = 16,
    parameter int WDG_TMO_TH0 = 1000,
    parameter int WDG_TMO_TH1 = 2000,
    parameter int WDG_TMO_TH2 = 4000,
    parameter int WDG_TMO_TH3 = 8000,
    parameter int RSP_GAP     = 4,
    parameter int CRC_ERR_TH  = 3,
    parameter int ACK_TMO_TH  = 64
) (
    input logic              i_clk,
    input logic              i_rst,
    hv_wdg_rsp_ctrl_if.slave bus
);

    localparam int CRC_W = $clog2(CRC_ERR_TH + 1);
    localparam logic [WDG_CNT_W-1:0] TMO_LIM0 = WDG_CNT_W'(WDG_TMO_TH0 - 1);
    localparam logic [WDG_CNT_W-1:0] TMO_LIM1 = WDG_CNT_W'(WDG_TMO_TH1 - 1);
    localparam logic [WDG_CNT_W-1:0] TMO_LIM2 = WDG_CNT_W'(WDG_TMO_TH2 - 1);
    localparam logic [WDG_CNT_W-1:0] TMO_LIM3 = WDG_CNT_W'(WDG_TMO_TH3 - 1);
    localparam logic [WDG_CNT_W-1:0] GAP_LAST = WDG_CNT_W'(RSP_GAP - 1);
    localparam logic [CRC_W-1:0]     CRC_SAT  = CRC_W'(CRC_ERR_TH);

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_REQ} state_t;

    state_t               state_q, state_n;
    logic [WDG_CNT_W-1:0] gap_cnt_q, gap_cnt_n;
    logic [WDG_CNT_W-1:0] tmo_cnt_q, tmo_lim;
    logic [CRC_W-1:0]     crc_cnt_q, crc_cnt_n;
    logic                 pend_q, pend_n;
    logic                 req_q, ovr_q, ovr_n, capture;
    logic                 lv_lost_q, alarm_q, lv_seen_q, crc_seen_q;
    logic [1:0]           status_q;
    logic                 en, good, bad, tmo_hit;

    assign en      = bus.i_wdg_en;
    assign good    = en & bus.i_owt_rx_frm_vld & bus.i_owt_rx_frm_is_wdg & ~bus.i_owt_rx_frm_crc_err;
    assign bad     = en & bus.i_owt_rx_frm_vld & bus.i_owt_rx_frm_crc_err;
    assign tmo_hit = (tmo_cnt_q >= tmo_lim);

    always_comb begin
        tmo_lim = TMO_LIM0;
        case (bus.i_wdgtmo_config)
            2'd1:    tmo_lim = TMO_LIM1;
            2'd2:    tmo_lim = TMO_LIM2;
            2'd3:    tmo_lim = TMO_LIM3;
            default: tmo_lim = TMO_LIM0;
        endcase
    end

    always_comb begin
        crc_cnt_n = crc_cnt_q;
        if (good)
            crc_cnt_n = '0;
        else if (bad && crc_cnt_q != CRC_SAT)
            crc_cnt_n = crc_cnt_q + CRC_W'(1);
    end

`ifdef HV_WDG_RSP_ACK_TMO_EN
    localparam logic [WDG_CNT_W-1:0] ACK_LAST = WDG_CNT_W'(ACK_TMO_TH - 1);
    logic [WDG_CNT_W-1:0] ack_cnt_q, ack_cnt_n;
    logic                 stall_q, stall_n;
`endif

    always_comb begin
        state_n   = state_q;
        gap_cnt_n = gap_cnt_q;
        pend_n    = pend_q;
        capture   = 1'b0;
        ovr_n     = good & pend_q;
`ifdef HV_WDG_RSP_ACK_TMO_EN
        ack_cnt_n = ack_cnt_q;
        stall_n   = 1'b0;
`endif
        if (!en) begin
            state_n   = S_IDLE;
            gap_cnt_n = '0;
            pend_n    = 1'b0;
            ovr_n     = 1'b0;
`ifdef HV_WDG_RSP_ACK_TMO_EN
            ack_cnt_n = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A parked frame is served first; a new frame arriving now is the overflow case.
                    if (pend_q) begin
                        state_n   = S_GAP;
                        gap_cnt_n = '0;
                        pend_n    = 1'b0;
                    end else if (good) begin
                        state_n   = S_GAP;
                        gap_cnt_n = '0;
                    end
                end
                S_GAP: begin
                    if (good && !pend_q) pend_n = 1'b1;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_n = S_REQ;
                        capture = 1'b1;
`ifdef HV_WDG_RSP_ACK_TMO_EN
                        ack_cnt_n = '0;
`endif
                    end else begin
                        gap_cnt_n = gap_cnt_q + WDG_CNT_W'(1);
                    end
                end
                S_REQ: begin
                    if (good && !pend_q) pend_n = 1'b1;
                    if (bus.i_owt_tx_wdg_rsp_ack) begin
                        state_n = S_IDLE;
`ifdef HV_WDG_RSP_ACK_TMO_EN
                    end else if (ack_cnt_q == ACK_LAST) begin
                        state_n = S_IDLE;
                        stall_n = 1'b1;
                    end else begin
                        ack_cnt_n = ack_cnt_q + WDG_CNT_W'(1);
`endif
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            gap_cnt_q <= '0;
            pend_q    <= 1'b0;
            req_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            gap_cnt_q <= gap_cnt_n;
            pend_q    <= pend_n;
            req_q     <= (state_n == S_REQ);
            ovr_q     <= ovr_n;
        end
    end

`ifdef HV_WDG_RSP_ACK_TMO_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ack_cnt_q <= '0;
            stall_q   <= 1'b0;
        end else begin
            ack_cnt_q <= ack_cnt_n;
            stall_q   <= stall_n;
        end
    end
    assign bus.o_wdg_tx_stall = stall_q;
`else
    assign bus.o_wdg_tx_stall = 1'b0;
`endif

    // Seen-latches snapshot the conditions for the payload, since lv_lost itself
    // clears on the very frame that triggers the response.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tmo_cnt_q  <= '0;
            lv_lost_q  <= 1'b0;
            crc_cnt_q  <= '0;
            alarm_q    <= 1'b0;
            lv_seen_q  <= 1'b0;
            crc_seen_q <= 1'b0;
            status_q   <= 2'b00;
        end else if (!en) begin
            tmo_cnt_q  <= '0;
            lv_lost_q  <= 1'b0;
            crc_cnt_q  <= '0;
            alarm_q    <= 1'b0;
            lv_seen_q  <= 1'b0;
            crc_seen_q <= 1'b0;
            status_q   <= 2'b00;
        end else begin
            if (good)
                tmo_cnt_q <= '0;
            else if (!tmo_hit)
                tmo_cnt_q <= tmo_cnt_q + WDG_CNT_W'(1);
            if (good)
                lv_lost_q <= 1'b0;
            else if (tmo_hit)
                lv_lost_q <= 1'b1;
            crc_cnt_q  <= crc_cnt_n;
            alarm_q    <= (crc_cnt_n == CRC_SAT);
            lv_seen_q  <= (lv_seen_q & ~capture) | lv_lost_q;
            crc_seen_q <= (crc_seen_q & ~capture) | bad;
            if (capture)
                status_q <= {lv_seen_q, crc_seen_q};
        end
    end

    assign bus.o_wdg_owt_tx_rsp_req = req_q;
    assign bus.o_wdg_rsp_status     = status_q;
    assign bus.o_wdg_lv_lost        = lv_lost_q;
    assign bus.o_wdg_crc_err_alarm  = alarm_q;
    assign bus.o_wdg_rsp_ovr        = ovr_q;

endmodule

// File: tb/tb_hv_wdg_rsp_ctrl.sv
// Bench for hv_wdg_rsp_ctrl: directed scenarios plus random traffic against a cycle reference model.
module tb_hv_wdg_rsp_ctrl;
  localparam int GAP = 4;
  localparam int CTH = 3;
  localparam int ATH = 8;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  hv_wdg_rsp_ctrl_if bus();

  hv_wdg_rsp_ctrl #(
    .WDG_CNT_W(16), .WDG_TMO_TH0(20), .WDG_TMO_TH1(30), .WDG_TMO_TH2(40), .WDG_TMO_TH3(50),
    .RSP_GAP(GAP), .CRC_ERR_TH(CTH), .ACK_TMO_TH(ATH)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus(bus)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int th_tab[4] = '{20, 30, 40, 50};

  // reference state
  int         m_since, m_crc, m_gap, m_ackw;
  bit         m_lv, m_alarm, m_lv_seen, m_crc_seen, m_req, m_pend, m_ovr, m_stall;
  logic [1:0] m_status;
  logic [1:0] cur_cfg = 2'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_since = 0; m_crc = 0; m_gap = -1; m_ackw = 0;
    m_lv = 0; m_alarm = 0; m_lv_seen = 0; m_crc_seen = 0;
    m_req = 0; m_pend = 0; m_ovr = 0; m_stall = 0; m_status = 2'b00;
  endtask

  task automatic model_step(input bit en, vld, wdg, crc, input logic [1:0] cfg, input bit ack);
    bit good, bad, cap, old_lv, ovr, stall;
    good = en && vld && wdg && !crc;
    bad  = en && vld && crc;
    if (!en) begin
      model_reset();
    end else begin
      cap = 0; stall = 0; ovr = good && m_pend; old_lv = m_lv;
      if (m_req) begin
        if (good && !m_pend) m_pend = 1;
        if (ack) m_req = 0;
`ifdef HV_WDG_RSP_ACK_TMO_EN
        else if (m_ackw == ATH - 1) begin m_req = 0; stall = 1; end
        else m_ackw++;
`endif
      end else if (m_gap >= 0) begin
        if (good && !m_pend) m_pend = 1;
        if (m_gap == GAP - 1) begin cap = 1; m_gap = -1; m_req = 1; m_ackw = 0; end
        else m_gap++;
      end else begin
        if (m_pend) begin m_pend = 0; m_gap = 0; end
        else if (good) m_gap = 0;
      end
      if (cap) m_status = {m_lv_seen, m_crc_seen};
      m_lv_seen  = (cap ? 1'b0 : m_lv_seen) | old_lv;
      m_crc_seen = (cap ? 1'b0 : m_crc_seen) | bad;
      m_lv    = good ? 1'b0 : (m_lv || (m_since >= th_tab[cfg] - 1));
      m_since = good ? 0 : m_since + 1;
      if (good) m_crc = 0;
      else if (bad && m_crc < CTH) m_crc++;
      m_alarm = (m_crc == CTH);
      m_ovr = ovr; m_stall = stall;
    end
  endtask

  task automatic tick(input bit en, vld, wdg, crc, input bit ack);
    bus.i_wdg_en             = en;
    bus.i_owt_rx_frm_vld     = vld;
    bus.i_owt_rx_frm_is_wdg  = wdg;
    bus.i_owt_rx_frm_crc_err = crc;
    bus.i_wdgtmo_config      = cur_cfg;
    bus.i_owt_tx_wdg_rsp_ack = ack;
    @(posedge i_clk);
    model_step(en, vld, wdg, crc, cur_cfg, ack);
    #1;
    chk("req",    bus.o_wdg_owt_tx_rsp_req, m_req);
    chk("status", bus.o_wdg_rsp_status,     m_status);
    chk("lvlost", bus.o_wdg_lv_lost,        m_lv);
    chk("alarm",  bus.o_wdg_crc_err_alarm,  m_alarm);
    chk("ovr",    bus.o_wdg_rsp_ovr,        m_ovr);
    chk("stall",  bus.o_wdg_tx_stall,       m_stall);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0);
  endtask
  task automatic good_frm();  tick(1, 1, 1, 0, 0); endtask
  task automatic bad_frm();   tick(1, 1, 1, 1, 0); endtask
  task automatic ack1();      tick(1, 0, 0, 0, 1); endtask
  task automatic restart();   tick(0, 0, 0, 0, 0); endtask

  initial begin
    model_reset();
    bus.i_wdg_en = 0; bus.i_owt_rx_frm_vld = 0; bus.i_owt_rx_frm_is_wdg = 0;
    bus.i_owt_rx_frm_crc_err = 0; bus.i_wdgtmo_config = 0; bus.i_owt_tx_wdg_rsp_ack = 0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_req",    bus.o_wdg_owt_tx_rsp_req, 0);
    chk("rst_status", bus.o_wdg_rsp_status,     0);
    chk("rst_lv",     bus.o_wdg_lv_lost,        0);
    i_rst = 1'b0;

    // basic response: req after RSP_GAP+1, drops after ack
    idle(2);
    good_frm();
    idle(3);
    chk("basic_gap_req", bus.o_wdg_owt_tx_rsp_req, 0);
    idle(1);
    chk("basic_req",    bus.o_wdg_owt_tx_rsp_req, 1);
    chk("basic_status", bus.o_wdg_rsp_status,     2'b00);
    idle(4);
    chk("basic_hold", bus.o_wdg_owt_tx_rsp_req, 1);
    ack1();
    chk("basic_drop", bus.o_wdg_owt_tx_rsp_req, 0);
    idle(2);

    // LV lost after TH0 cycles, cleared by a good frame, reported in status
    restart();
    idle(19);
    chk("lv_before", bus.o_wdg_lv_lost, 0);
    idle(1);
    chk("lv_set", bus.o_wdg_lv_lost, 1);
    idle(3);
    chk("lv_sticky", bus.o_wdg_lv_lost, 1);
    good_frm();
    chk("lv_clr", bus.o_wdg_lv_lost, 0);
    idle(4);
    chk("lv_req",    bus.o_wdg_owt_tx_rsp_req, 1);
    chk("lv_status", bus.o_wdg_rsp_status,     2'b10);
    ack1();

    // CRC alarm after 3 consecutive bad frames
    restart();
    bad_frm(); bad_frm();
    chk("crc_two", bus.o_wdg_crc_err_alarm, 0);
    bad_frm();
    chk("crc_alarm", bus.o_wdg_crc_err_alarm, 1);
    chk("crc_noreq", bus.o_wdg_owt_tx_rsp_req, 0);
    good_frm();
    chk("crc_clr", bus.o_wdg_crc_err_alarm, 0);
    idle(4);
    chk("crc_req",    bus.o_wdg_owt_tx_rsp_req, 1);
    chk("crc_status", bus.o_wdg_rsp_status,     2'b01);
    ack1();

    // overflow: third back-to-back frame is dropped
    restart();
    good_frm(); good_frm();
    chk("ovr_none", bus.o_wdg_rsp_ovr, 0);
    good_frm();
    chk("ovr_pulse", bus.o_wdg_rsp_ovr, 1);
    idle(1);
    chk("ovr_end", bus.o_wdg_rsp_ovr, 0);
    idle(1);
    chk("ovr_req1", bus.o_wdg_owt_tx_rsp_req, 1);
    ack1();
    chk("ovr_drop", bus.o_wdg_owt_tx_rsp_req, 0);
    idle(4);
    chk("ovr_gap2", bus.o_wdg_owt_tx_rsp_req, 0);
    idle(1);
    chk("ovr_req2", bus.o_wdg_owt_tx_rsp_req, 1);
    ack1();
    idle(6);
    chk("ovr_done", bus.o_wdg_owt_tx_rsp_req, 0);

    // frame coinciding with ack re-enters GAP via IDLE
    restart();
    good_frm(); idle(4);
    tick(1, 1, 1, 0, 1);
    chk("ackfrm_drop", bus.o_wdg_owt_tx_rsp_req, 0);
    idle(5);
    chk("ackfrm_req", bus.o_wdg_owt_tx_rsp_req, 1);
    ack1();

    // no ack
    restart();
    good_frm(); idle(4);
    chk("noack_req", bus.o_wdg_owt_tx_rsp_req, 1);
`ifdef HV_WDG_RSP_ACK_TMO_EN
    idle(ATH - 1);
    chk("tmo_hold", bus.o_wdg_owt_tx_rsp_req, 1);
    idle(1);
    chk("tmo_drop",  bus.o_wdg_owt_tx_rsp_req, 0);
    chk("tmo_stall", bus.o_wdg_tx_stall,       1);
    idle(1);
    chk("tmo_stall_end", bus.o_wdg_tx_stall, 0);
`else
    idle(1000);
    chk("noack_hold",  bus.o_wdg_owt_tx_rsp_req, 1);
    chk("noack_stall", bus.o_wdg_tx_stall,       0);
`endif

    // async reset mid-REQ
    restart();
    good_frm(); idle(4);
    chk("ar_req", bus.o_wdg_owt_tx_rsp_req, 1);
    #2 i_rst = 1'b1;
    #1;
    chk("ar_req0",    bus.o_wdg_owt_tx_rsp_req, 0);
    chk("ar_status0", bus.o_wdg_rsp_status,     0);
    chk("ar_lv0",     bus.o_wdg_lv_lost,        0);
    chk("ar_alarm0",  bus.o_wdg_crc_err_alarm,  0);
    model_reset();
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    idle(6);
    chk("ar_idle", bus.o_wdg_owt_tx_rsp_req, 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit en, vld, wdg, crc, ack;
      if ($urandom_range(0, 39) == 0) cur_cfg = 2'($urandom_range(0, 3));
      en  = ($urandom_range(0, 149) != 0);
      vld = ($urandom_range(0, 5) == 0);
      wdg = ($urandom_range(0, 3) != 0);
      crc = ($urandom_range(0, 4) == 0);
      ack = ($urandom_range(0, 5) == 0);
      tick(en, vld, wdg, crc, ack);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
